// File: rtl/dm_responder.sv
// Shared byte-wide data memory serving NUM_CORES ports through a round-robin arbiter.
// One access per cycle; grant/rvalid/err pulse the cycle after the winning request.
module dm_responder #(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CORES-1:0]            req,
   input  logic [NUM_CORES-1:0]            wr,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_CORES*16-1:0]         wdata,
   output logic [NUM_CORES-1:0]            grant,
   output logic [NUM_CORES-1:0]            rvalid,
   output logic [NUM_CORES*DATA_WIDTH-1:0] rdata,
   output logic [NUM_CORES-1:0]            err
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_WIDTH-1:0]                 mem_q [0:DEPTH-1];
   logic [PTR_W-1:0]                      ptr_q, ptr_d;
   logic [NUM_CORES-1:0]                  grant_q, rvalid_q, err_q;
   logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  rdata_q;

   logic [NUM_CORES-1:0]  elig;
   logic                  win_valid;
   logic [PTR_W-1:0]      win_idx;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] mem_idx;

   // A core granted last cycle is masked so its falling req cannot win twice.
   assign elig = req & ~grant_q;

   // Scan from the highest offset down so the nearest eligible index after ptr wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         int cand;
         cand = (int'(ptr_q) + k) % NUM_CORES;
         if (elig[cand]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (win_valid) begin
         ptr_d = (win_idx == PTR_W'(NUM_CORES - 1)) ? '0 : win_idx + PTR_W'(1);
      end
   end

   assign w_addr   = addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_wr     = wr[win_idx];
   assign w_data   = wdata[win_idx*16 +: DATA_WIDTH];
   assign in_range = (w_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
   assign mem_idx  = w_addr[DEPTH_LOG2-1:0];

   // Memory has no reset; an access coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (rst_n && win_valid && w_wr && in_range) begin
         mem_q[mem_idx] <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         grant_q  <= '0;
         rvalid_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         grant_q  <= '0;
         rvalid_q <= '0;
         err_q    <= '0;
         if (win_valid) begin
            grant_q[win_idx] <= 1'b1;
            err_q[win_idx]   <= ~in_range;
            if (!w_wr) begin
               rvalid_q[win_idx] <= 1'b1;
               rdata_q[win_idx]  <= in_range ? mem_q[mem_idx] : '0;
            end
         end
      end
   end

   assign grant  = grant_q;
   assign rvalid = rvalid_q;
   assign err    = err_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, hand sequences for contention and
// reset-during-access, then random traffic checked against a rule-level memory model.
module tb_dm_responder;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req, wr;
   logic [63:0] addr, wdata;
   logic [3:0]  grant, rvalid, err;
   logic [31:0] rdata;

   dm_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .grant (grant),
      .rvalid(rvalid),
      .rdata (rdata),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: what the outputs must be after the next edge.
   logic [7:0] mem_m [0:1023];
   bit         known_m [0:1023];
   int         ptr_m;
   logic [3:0] g_m, v_m, e_m;
   logic [7:0] rd_m [0:3];
   bit         rdk_m [0:3];

   task automatic model_step(input logic [3:0] r, input logic [3:0] w,
                             input logic [63:0] a, input logic [63:0] d, input logic rn);
      int win;
      win = -1;
      if (!rn) begin
         ptr_m = 0;
         g_m = '0; v_m = '0; e_m = '0;
         for (int i = 0; i < 4; i++) begin
            rd_m[i]  = 8'h00;
            rdk_m[i] = 1'b1;
         end
         return;
      end
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (ptr_m + k) % 4;
         if (win < 0 && r[c] && !g_m[c]) win = c;
      end
      g_m = '0; v_m = '0; e_m = '0;
      if (win >= 0) begin
         int ad;
         ad = int'(a[win*16 +: 16]);
         g_m[win] = 1'b1;
         e_m[win] = (ad >= 1024);
         if (w[win]) begin
            if (ad < 1024) begin
               mem_m[ad]   = d[win*16 +: 8];
               known_m[ad] = 1'b1;
            end
         end else begin
            v_m[win] = 1'b1;
            if (ad >= 1024) begin
               rd_m[win]  = 8'h00;
               rdk_m[win] = 1'b1;
            end else begin
               rd_m[win]  = mem_m[ad];
               rdk_m[win] = known_m[ad];
            end
         end
         ptr_m = (win + 1) % 4;
      end
   endtask

   task automatic check_model(input string tag);
      n_cmp++;
      if ({grant, rvalid, err} !== {g_m, v_m, e_m}) begin
         n_err++;
         $display("FAIL %s outs: got g=%b v=%b e=%b want g=%b v=%b e=%b",
                  tag, grant, rvalid, err, g_m, v_m, e_m);
      end
      for (int i = 0; i < 4; i++) begin
         if (rdk_m[i]) begin
            n_cmp++;
            if (rdata[i*8 +: 8] !== rd_m[i]) begin
               n_err++;
               $display("FAIL %s rdata[%0d]: got %h want %h", tag, i, rdata[i*8 +: 8], rd_m[i]);
            end
         end
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] w,
                       input logic [63:0] a, input logic [63:0] d, input logic rn,
                       input string tag);
      @(negedge clk);
      req = r; wr = w; addr = a; wdata = d; rst_n = rn;
      model_step(r, w, a, d, rn);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [3:0]  eg;
      logic [3:0]  ev;
      logic [3:0]  ee;
      int          chk_core;
      logic [7:0]  erd;
   } vec_t;

   vec_t vec [0:9];

   initial begin
      logic [3:0]  prev_g;
      logic [63:0] ra, rd;
      logic [3:0]  rr, rw;

      for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;
      for (int i = 0; i < 4; i++) rdk_m[i] = 1'b0;
      ptr_m = 0; g_m = '0; v_m = '0; e_m = '0;
      rst_n = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0;

      vec[0] = '{4'b1111, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'h0, 16'h005A},
                 4'b0001, 4'b0000, 4'b0000, -1, 8'h00};
      vec[1] = '{4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0010, 16'h0}, {16'h0, 16'h0, 16'h00A5, 16'h0},
                 4'b0010, 4'b0000, 4'b0000, -1, 8'h00};
      vec[2] = '{4'b0010, 4'b0000, {16'h0, 16'h0, 16'h0010, 16'h0}, 64'h0,
                 4'b0000, 4'b0000, 4'b0000, -1, 8'h00};
      vec[3] = '{4'b0010, 4'b0000, {16'h0, 16'h0, 16'h0010, 16'h0}, 64'h0,
                 4'b0010, 4'b0010, 4'b0000, 1, 8'hA5};
      vec[4] = '{4'b0000, 4'b0000, 64'h0, 64'h0,
                 4'b0000, 4'b0000, 4'b0000, 1, 8'hA5};
      vec[5] = '{4'b0100, 4'b0100, {16'h0, 16'h0005, 16'h0, 16'h0}, {16'h0, 16'h003C, 16'h0, 16'h0},
                 4'b0100, 4'b0000, 4'b0000, -1, 8'h00};
      vec[6] = '{4'b1000, 4'b0000, {16'h0005, 16'h0, 16'h0, 16'h0}, 64'h0,
                 4'b1000, 4'b1000, 4'b0000, 3, 8'h3C};
      vec[7] = '{4'b0001, 4'b0000, {16'h0, 16'h0, 16'h0, 16'h0400}, 64'h0,
                 4'b0001, 4'b0001, 4'b0001, 0, 8'h00};
      vec[8] = '{4'b0010, 4'b0010, {16'h0, 16'h0, 16'h8001, 16'h0}, {16'h0, 16'h0, 16'h00FF, 16'h0},
                 4'b0010, 4'b0000, 4'b0010, -1, 8'h00};
      vec[9] = '{4'b0100, 4'b0000, {16'h0, 16'h0001, 16'h0, 16'h0}, 64'h0,
                 4'b0100, 4'b0100, 4'b0000, 2, 8'h5A};

      // Reset with all cores requesting: every output must read zero.
      for (int c = 0; c < 2; c++) begin
         step(4'b1111, 4'b0000, 64'h0, 64'h0, 1'b0, "reset");
         n_cmp++;
         if ({grant, rvalid, err, rdata} !== 44'h0) begin
            n_err++;
            $display("FAIL reset_zero: got g=%b v=%b e=%b rd=%h want all 0", grant, rvalid, err, rdata);
         end
      end

      for (int k = 0; k < 10; k++) begin
         step(vec[k].req, vec[k].wr, vec[k].addr, vec[k].wdata, 1'b1, $sformatf("vec%0d", k));
         n_cmp++;
         if ({grant, rvalid, err} !== {vec[k].eg, vec[k].ev, vec[k].ee}) begin
            n_err++;
            $display("FAIL vec%0d pulses: got g=%b v=%b e=%b want g=%b v=%b e=%b", k,
                     grant, rvalid, err, vec[k].eg, vec[k].ev, vec[k].ee);
         end
         if (vec[k].chk_core >= 0) begin
            n_cmp++;
            if (rdata[vec[k].chk_core*8 +: 8] !== vec[k].erd) begin
               n_err++;
               $display("FAIL vec%0d rdata[%0d]: got %h want %h", k, vec[k].chk_core,
                        rdata[vec[k].chk_core*8 +: 8], vec[k].erd);
            end
         end
      end

      // Full contention: one onehot grant per cycle, never the same core twice in a row.
      prev_g = grant;
      for (int c = 0; c < 12; c++) begin
         step(4'b1111, 4'b0000, {4{16'h0010}}, 64'h0, 1'b1, "contend");
         n_cmp++;
         if (!$onehot(grant) || (grant & prev_g) != 4'b0000) begin
            n_err++;
            $display("FAIL contend_rr cycle %0d: got g=%b prev=%b want onehot, disjoint", c, grant, prev_g);
         end
         prev_g = grant;
      end

      // Reset lands in the cycle core1 would win a write to 0x20.
      step(4'b0000, 4'b0000, 64'h0, 64'h0, 1'b1, "idle");
      step(4'b0001, 4'b0001, {48'h0, 16'h0020}, {48'h0, 16'h0011}, 1'b1, "pre_wr");
      step(4'b0000, 4'b0000, 64'h0, 64'h0, 1'b1, "idle");
      step(4'b0010, 4'b0010, {32'h0, 16'h0020, 16'h0}, {32'h0, 16'h0077, 16'h0}, 1'b0, "rst_mid");
      n_cmp++;
      if (grant !== 4'b0000) begin
         n_err++;
         $display("FAIL rst_mid_grant: got %b want 0000", grant);
      end
      step(4'b0001, 4'b0000, {48'h0, 16'h0020}, 64'h0, 1'b1, "post_rst");
      n_cmp++;
      if (grant !== 4'b0001 || rdata[7:0] !== 8'h11) begin
         n_err++;
         $display("FAIL post_rst_read: got g=%b rd=%h want g=0001 rd=11", grant, rdata[7:0]);
      end

      // Random traffic with occasional out-of-range addresses and resets.
      for (int c = 0; c < 400; c++) begin
         rr = 4'($urandom_range(0, 15));
         rw = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0)
               ra[i*16 +: 16] = 16'h0400 + 16'($urandom_range(0, 16'hFBFF));
            else
               ra[i*16 +: 16] = 16'($urandom_range(0, 15));
            rd[i*16 +: 16] = 16'($urandom);
         end
         step(rr, rw, ra, rd, ($urandom_range(0, 49) != 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
